// File: rtl/bsg_clkgen_div_gated_if.sv
// Control and output bundle for the gated clock divider.
// The divider is the slave; whoever sets the enable and divide value is the master.
interface bsg_clkgen_div_gated_if #(
  parameter int width_p = 8
);
  logic               en_i;
  logic [width_p-1:0] div_i;
  logic               clk_o;
  logic               tick_o;
  logic               busy_o;

  modport master (output en_i, div_i, input clk_o, tick_o, busy_o);
  modport slave  (input en_i, div_i, output clk_o, tick_o, busy_o);
endinterface

// File: rtl/bsg_clkgen_div_gated.sv
// Programmable clock divider with glitch-free enable/disable.
// Divided period is 2*(div+1) core cycles; every high phase completes unless reset cuts it short.
module bsg_clkgen_div_gated #(
  parameter int width_p = 8
) (
  input logic                           clk_i,
  input logic                           reset_n_i,
  bsg_clkgen_div_gated_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e             state;
  logic [width_p-1:0] counter;
  logic [width_p-1:0] div_r;
  logic               clk_r;
  logic               tick_r;
  logic               at_end;

  // Only the shadowed divide value is compared, so div_i never disturbs a phase in progress.
  assign at_end = (counter == div_r);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      counter <= '0;
      div_r   <= '0;
      clk_r   <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      // NOTE: default assignment first; a later non-blocking assignment in the same block overrides it.
      tick_r <= 1'b0;
      case (state)
        IDLE: begin
          counter <= '0;
          clk_r   <= 1'b0;
          if (bus.en_i) begin
            div_r <= bus.div_i;
            state <= RUN;
          end
        end

        RUN: begin
          if (!bus.en_i && !clk_r) begin
            // Stopping in the low phase only stretches the low level.
            counter <= '0;
            state   <= IDLE;
          end else if (at_end) begin
            counter <= '0;
            clk_r   <= ~clk_r;
            if (!clk_r) begin
              tick_r <= 1'b1;
            end else begin
              div_r <= bus.div_i;
              if (!bus.en_i) state <= IDLE;
            end
          end else begin
            counter <= counter + 1'b1;
            if (!bus.en_i) state <= STOP;
          end
        end

        STOP: begin
          // Finish the high phase at full length, then park low.
          if (at_end) begin
            counter <= '0;
            clk_r   <= 1'b0;
            state   <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end

        default: begin
          counter <= '0;
          clk_r   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.clk_o  = clk_r;
  assign bus.tick_o = tick_r;
  assign bus.busy_o = (state != IDLE);

endmodule

// File: tb/tb_bsg_clkgen_div_gated.sv
// Directed bench for bsg_clkgen_div_gated: expected {clk_o,tick_o,busy_o} per cycle are queued
// from the period formulas and compared one per cycle on the falling core-clock edge.
module tb_bsg_clkgen_div_gated;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bsg_clkgen_div_gated_if #(.width_p(W)) bus ();

  bsg_clkgen_div_gated #(.width_p(W)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus.slave)
  );

  logic [2:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic logic [2:0] obs();
    return {bus.clk_o, bus.tick_o, bus.busy_o};
  endfunction

  task automatic check(input string tag, input logic [2:0] o, input logic [2:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed clk/tick/busy=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic push(input int n, input logic [2:0] first, input logic [2:0] rest);
    for (int i = 0; i < n; i++) exp_q.push_back((i == 0) ? first : rest);
  endtask

  task automatic push_low(input int n);  push(n, 3'b001, 3'b001); endtask
  task automatic push_high(input int n); push(n, 3'b111, 3'b101); endtask
  task automatic push_idle(input int n); push(n, 3'b000, 3'b000); endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed clk/tick/busy=%b expected=<scoreboard empty>", tag, obs());
    end else begin
      check(tag, obs(), exp_q.pop_front());
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.en_i   = 1'b0;
    bus.div_i  = '0;
    #3 check("reset_state", obs(), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(2);
    run("idle_after_reset", 2);

    // Basic divide by 2*(2+1); disabling on the last high cycle falls straight to idle.
    bus.div_i = 8'd2;
    bus.en_i  = 1'b1;
    push_low(3); push_high(3); push_low(3); push_high(3);
    run("basic_div2", 12);
    bus.en_i = 1'b0;
    push_idle(2);
    run("basic_stop", 2);

    // Minimum divide: clk_o toggles every cycle, tick every other cycle.
    bus.div_i = 8'd0;
    bus.en_i  = 1'b1;
    push_low(1);
    for (int i = 0; i < 3; i++) begin
      push_high(1);
      push_low(1);
    end
    run("div0", 7);
    bus.en_i = 1'b0;
    push_idle(2);
    run("div0_stop", 2);

    // Disable one cycle into the high phase; re-enable during STOP is ignored.
    bus.div_i = 8'd3;
    bus.en_i  = 1'b1;
    push_low(4); push_high(4); push_idle(1);
    run("stop_hi_low", 4);
    run("stop_hi_rise", 1);
    bus.en_i = 1'b0;
    run("stop_hi_stop", 1);
    bus.en_i = 1'b1;
    run("stop_hi_ignored", 2);
    run("stop_hi_fall", 1);

    // Disable mid-low, then re-enable: first rise exactly div+1 cycles after sampling.
    push_low(2);
    run("stop_lo_low", 2);
    bus.en_i = 1'b0;
    push_idle(2);
    run("stop_lo_idle", 2);
    bus.en_i = 1'b1;
    push_low(4); push_high(4);
    run("stop_lo_reenable", 8);
    bus.en_i = 1'b0;
    push_idle(1);
    run("stop_lo_end", 1);

    // Divide change mid-high takes effect from the next period boundary (the fall).
    bus.div_i = 8'd1;
    bus.en_i  = 1'b1;
    push_low(2); push_high(2); push_low(5); push_high(5);
    run("divchg_old_low", 2);
    run("divchg_old_high", 1);
    bus.div_i = 8'd4;
    run("divchg_old_high", 1);
    run("divchg_new_period", 10);
    bus.en_i = 1'b0;
    push_idle(1);
    run("divchg_end", 1);

    // Asynchronous reset in the middle of a high phase.
    bus.div_i = 8'd5;
    bus.en_i  = 1'b1;
    push_low(6); push_high(2);
    run("async_pre", 8);
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", obs(), 3'b000);
    @(negedge clk);
    check("async_reset_held", obs(), 3'b000);
    rst_n = 1'b1;
    push_low(6); push_high(6); push_idle(1);
    run("async_restart_low", 6);
    run("async_restart_rise", 1);
    bus.en_i = 1'b0;
    run("async_restart_stop", 5);
    run("async_restart_fall", 1);

    // Largest divide: counter reaches all-ones and wraps cleanly.
    bus.div_i = 8'hFF;
    bus.en_i  = 1'b1;
    push_low(256); push_high(256);
    run("div_max", 512);
    bus.en_i = 1'b0;
    push_idle(1);
    run("div_max_end", 1);

    compared++;
    assert (exp_q.size() === 0) else begin
      mismatched++;
      $error("FAIL scoreboard_drained: observed %0d leftover entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
